hazard_fwd_unit: RTL

- Parametrised hazard-detection and forwarding controller for the in-order integer pipeline. It replaces the fixed two-operand, two-stage fwdA/fwdB logic in the pipeline top.
- Keeps its own shadow scoreboard of in-flight destination registers, one entry per downstream stage.
- Raises a decode stall on load-use hazards and produces registered per-operand forwarding selects aligned to the execute stage.
- Supports flush (branch/jump redirect), an external whole-pipe hold, and a saturating stall-cycle counter.

---
 rtl/hazard_fwd_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_unit
//  Description : Hazard detection and operand-forwarding controller for the
//                in-order integer pipeline. Tracks in-flight destination
//                registers in a shadow scoreboard, stalls decode on load-use
//                hazards and emits per-operand forwarding selects aligned to
//                the execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit #(
    parameter int REG_W    = 5,
    parameter int NSRC     = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [NSRC*REG_W-1:0]   id_rs,
    input  logic [NSRC-1:0]         id_rs_used,
    input  logic [REG_W-1:0]        id_rd,
    input  logic                    id_regwrite,
    input  logic                    id_is_load,
    input  logic                    flush,
    input  logic                    ext_hold,
    output logic                    stall,
    output logic [NSRC*SEL_W-1:0]   ex_fwd_sel,
    output logic                    ex_valid,
    output logic [15:0]             stall_count
);

    // Scoreboard: entry k describes the instruction k stages beyond decode.
    logic                   r_sb_v  [1:DEPTH];
    logic [REG_W-1:0]       r_sb_rd [1:DEPTH];
    logic                   r_sb_ld [1:DEPTH];

    logic [NSRC*SEL_W-1:0]  r_ex_fwd_sel;
    logic                   r_ex_valid;
    logic [15:0]            r_stall_count;

    logic [NSRC-1:0]        w_haz_vec;
    logic [NSRC*SEL_W-1:0]  w_sel;
    logic                   w_stall;
    logic                   w_bubble;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        logic [REG_W-1:0] w_rs;
        logic             w_hit;
        logic [SEL_W-1:0] w_k;
        logic             w_ld_hit;
        logic             w_near;

        assign w_rs = id_rs[gi*REG_W +: REG_W];

        // Find the nearest real writer of this operand; scanning far-to-near
        // lets the nearest match overwrite any farther one.
        always_comb begin
            w_hit    = 1'b0;
            w_k      = '0;
            w_ld_hit = 1'b0;
            w_near   = 1'b0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (id_valid && id_rs_used[gi] && r_sb_v[k] &&
                    (r_sb_rd[k] != '0) && (r_sb_rd[k] == w_rs)) begin
                    w_hit    = 1'b1;
                    w_k      = SEL_W'(k);
                    w_ld_hit = r_sb_ld[k];
                    w_near   = (k <= LOAD_LAT);
                end
            end
        end

        // A load whose data is not yet on a bus blocks forwarding entirely.
        assign w_haz_vec[gi] = w_hit & w_ld_hit & w_near;
        assign w_sel[gi*SEL_W +: SEL_W] = (w_hit && !w_haz_vec[gi]) ? w_k : '0;
    end

    // Flush discards the consumer, so a pending hazard is moot; reset
    // forces stall low even before the cleared state propagates.
    assign w_stall  = (|w_haz_vec) & ~flush & ~reset;
    assign w_bubble = flush | w_stall;

    // Scoreboard advance, EX-stage select registers and stall counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_sb_v[k]  <= 1'b0;
                r_sb_rd[k] <= '0;
                r_sb_ld[k] <= 1'b0;
            end
            r_ex_fwd_sel  <= '0;
            r_ex_valid    <= 1'b0;
            r_stall_count <= 16'd0;
        end else if (!ext_hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_sb_v[k]  <= r_sb_v[k-1];
                r_sb_rd[k] <= r_sb_rd[k-1];
                r_sb_ld[k] <= r_sb_ld[k-1];
            end
            if (w_bubble) begin
                r_sb_v[1]    <= 1'b0;
                r_sb_rd[1]   <= '0;
                r_sb_ld[1]   <= 1'b0;
                r_ex_fwd_sel <= '0;
                r_ex_valid   <= 1'b0;
            end else begin
                r_sb_v[1]    <= id_valid & id_regwrite;
                r_sb_rd[1]   <= id_rd;
                r_sb_ld[1]   <= id_is_load;
                r_ex_fwd_sel <= w_sel;
                r_ex_valid   <= id_valid;
            end
            if (w_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign stall       = w_stall;
    assign ex_fwd_sel  = r_ex_fwd_sel;
    assign ex_valid    = r_ex_valid;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire
